word_packer: RTL
================

Name: word_packer

Overview:
- Parametrised, flow-controlled successor to the fixed-ratio concatenator in the Kyber512 datapath.
- Packs a stream of IN_W-bit words into OUT_W-bit words, with selectable lane order.
- Supports early flush of a partial word, and valid/ready back-pressure on both sides.
- Sits between the 32-bit AXI-facing input stream and the wide polynomial/hash buffers.

Parameters:
- IN_W, 32: input word width in bits; must be ≥ 1.
- OUT_W, 128: output word width in bits; must be an integer multiple of IN_W, otherwise elaboration fails.
- MSB_FIRST, 1: lane order. 1 puts the first accepted word in the top lane, o_data[OUT_W-1 -: IN_W]. 0 puts it in the bottom lane, o_data[IN_W-1:0].
- N, OUT_W/IN_W: words per output; derived, not overridable.
- CNT_W, $clog2(N+1): width of the word counter and of o_count; derived.

Ports:
- i_clk, input, 1: single clock; everything is synchronous to its rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_valid, input, 1: an input word is presented.
- o_ready, output, 1: the block can accept an input word this cycle.
- i_data, input, IN_W: input word.
- i_last, input, 1: the current input word ends a packet; flush even if the output word is partial.
- o_valid, output, 1: the output word is valid.
- i_ready, input, 1: the downstream side accepts the output word.
- o_data, output, OUT_W: packed output word.
- o_count, output, CNT_W: number of valid input words inside o_data, range 1..N.
- o_last, output, 1: this output word closes a packet.

Behaviour:
- Handshake rules:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - o_ready = !o_valid || i_ready. It is combinational and never depends on i_valid.
- Reset: while i_reset is high at a clock edge, these are cleared:
  - o_valid = 0, o_data = 0, o_count = 0, o_last = 0.
  - Internal accumulator = 0 and word counter cnt = 0.
  - o_ready is therefore 1 in the first cycle after reset.
  - Reset mid-packet discards the partial accumulation and any pending output word, with no flush.
- Accumulation, on each input transfer:
  - i_data is written into lane cnt.
  - The lane is counted from the top when MSB_FIRST=1 and from the bottom when MSB_FIRST=0.
  - cnt then increments.
- Completion: an input transfer completes the word when cnt == N-1 or i_last == 1. On the next clock edge:
  - o_data <= accumulator including the new word; unwritten lanes are forced to 0.
  - o_count <= cnt+1.
  - o_last <= i_last.
  - o_valid <= 1.
  - cnt <= 0 and accumulator <= 0.
- Latency: o_valid rises 1 cycle after the completing input transfer.
- Throughput: 1 input word per cycle, so 1 output per N cycles with no back-pressure.
- Output hold: while o_valid && !i_ready, o_data, o_count and o_last are stable and o_ready = 0.
- Output drain: after an output transfer with no simultaneous completion, o_valid <= 0. o_data keeps its last value; it is don't-care while o_valid = 0.
- Simultaneous output transfer and completion in the same cycle: the new word loads and o_valid stays 1 with no bubble.
- Partial flush (i_last with cnt < N-1), for example N=4 with 2 words and MSB_FIRST=1: o_data = {w0, w1, 0, 0}, o_count = 2, o_last = 1.
- i_last with cnt == N-1: a normal full word with o_last = 1.
- N == 1: degenerates to a registered pipeline stage. Every transfer completes, o_count = 1 and o_last = i_last.
- i_last without i_valid is ignored.
- Counter width is sized so cnt never wraps. cnt == N cannot occur because completion resets it.

Decomposition:
- Package kyber_stream_pkg holds:
  - a clog2-style helper function;
  - the shared width constants KYBER_BUS_W = 32 and KYBER_POLY_W = 128.
- No sub-module: the accumulator and the output register fit in one module of about 150-200 lines of RTL.
- An optional elaboration-time assertion block checks OUT_W % IN_W == 0.

Test Plan:
1. IN_W=32, OUT_W=128, MSB_FIRST=1, i_ready=1; send 1,2,3,4 on consecutive cycles -> one cycle after the 4th word: o_valid=1, o_data=0x00000001_00000002_00000003_00000004, o_count=4, o_last=0.
2. Same configuration with MSB_FIRST=0 -> o_data=0x00000004_00000003_00000002_00000001.
3. Send 0xAAAA_AAAA, then 0xBBBB_BBBB with i_last=1 -> o_data=0xAAAAAAAA_BBBBBBBB_00000000_00000000, o_count=2, o_last=1; the next packet starts at lane 0.
4. Hold i_ready=0 after a completed word -> o_ready=0 and o_data stable for 5 cycles. Raise i_ready while i_valid streams the next 4 words -> no word is lost or duplicated, and the output order is preserved.
5. Stream continuously with i_ready=1 for 16 words -> 4 outputs spaced exactly 4 cycles apart, o_valid high 1 cycle each, o_ready constantly 1.
6. Assert i_reset after 3 accepted words -> the next cycle shows o_valid=0, o_count=0, o_ready=1. Then send 4 new words -> the output holds only those 4 new words.

Source files
------------

// File: rtl/kyber_stream_pkg.sv
// Shared constants and helpers for the Kyber stream datapath blocks.
package kyber_stream_pkg;

   localparam int unsigned KYBER_BUS_W  = 32;
   localparam int unsigned KYBER_POLY_W = 128;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int unsigned clog2_ceil(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a stream of IN_W-bit words into OUT_W-bit words with selectable lane
// order, early flush on i_last, and valid/ready flow control on both sides.
module word_packer
   import kyber_stream_pkg::*;
#(
   parameter int unsigned IN_W      = KYBER_BUS_W,
   parameter int unsigned OUT_W     = KYBER_POLY_W,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned N        = OUT_W / IN_W,
   localparam int unsigned CNT_W    = clog2_ceil(N + 1)
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [IN_W-1:0]  i_data,
   input  logic             i_last,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_last
);

   // Reject width combinations that cannot be packed evenly.
   generate
      if ((IN_W < 1) || (OUT_W < IN_W) || ((OUT_W % IN_W) != 0)) begin : g_bad_widths
         $error("word_packer: OUT_W must be a nonzero integer multiple of IN_W");
      end
   endgenerate

   logic [OUT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;

   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_complete;
   int unsigned      w_lane;
   logic [OUT_W-1:0] w_merged;

   // Output register is free when empty or being drained this cycle.
   assign o_ready    = !o_valid || i_ready;
   assign w_in_xfer  = i_valid && o_ready;
   assign w_out_xfer = o_valid && i_ready;
   assign w_complete = w_in_xfer && ((r_cnt == CNT_W'(N - 1)) || i_last);

   // Merge the incoming word into its lane; lanes not yet written stay zero
   // because the accumulator is cleared whenever a word completes.
   always_comb begin
      w_lane   = MSB_FIRST ? (N - 1 - 32'(r_cnt)) : 32'(r_cnt);
      w_merged = r_acc;
      for (int unsigned k = 0; k < N; k++) begin
         if (w_lane == k) begin
            w_merged[k*IN_W +: IN_W] = i_data;
         end
      end
   end

   // Accumulator, word counter and registered output stage.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_count <= '0;
         o_last  <= 1'b0;
      end else begin
         // Drain first; a same-cycle completion below re-asserts o_valid
         // so back-to-back words leave no bubble.
         if (w_out_xfer) begin
            o_valid <= 1'b0;
         end
         if (w_in_xfer) begin
            if (w_complete) begin
               o_data  <= w_merged;
               o_count <= r_cnt + CNT_W'(1);
               o_last  <= i_last;
               o_valid <= 1'b1;
               r_acc   <= '0;
               r_cnt   <= '0;
            end else begin
               r_acc   <= w_merged;
               r_cnt   <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
